// File: rtl/event_tagger_array.sv
// Multi-channel time tagger: synchronised strobe/level inputs are stamped with a
// free-running counter and emitted one record at a time through a ready/ack stage.
module event_tagger_array #(
    parameter int N_CH    = 4,
    parameter int N_DELTA = 4,
    parameter int TS_W    = 36,
    parameter int ADDR    = 1,
    localparam int REC_W  = TS_W + N_CH + N_DELTA + 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_CH-1:0]    strobe_in,
    input  logic [N_DELTA-1:0] delta_in,
    input  logic [7:0]         reg_addr,
    input  logic [7:0]         reg_data,
    input  logic               reg_we,
    input  logic               data_ack,
    output logic               operate,
    output logic               data_rdy,
    output logic [REC_W-1:0]   data
);
    localparam logic [7:0] A_CTRL  = 8'(ADDR);
    localparam logic [7:0] A_SMASK = 8'(ADDR + 1);
    localparam logic [7:0] A_DMASK = 8'(ADDR + 2);

    logic               r_capture_en;
    logic               r_counter_en;
    logic [N_CH-1:0]    r_strobe_mask;
    logic [N_DELTA-1:0] r_delta_mask;
    logic [TS_W-1:0]    r_cnt;
    logic [N_CH-1:0]    r_s1, r_s2, r_s3;
    logic [N_DELTA-1:0] r_d1, r_d2, r_d3;
    logic               r_lost_pend;
    logic               r_rdy;
    logic [REC_W-1:0]   r_data;

    logic               w_wr_ctrl;
    logic               w_cnt_clr;
    logic [N_CH-1:0]    w_strobe_ev;
    logic [N_DELTA-1:0] w_delta_ev;
    logic               w_wrap;
    logic               w_event;
    logic               w_slot_free;
    logic               w_unused;

    assign w_wr_ctrl   = reg_we && (reg_addr == A_CTRL);
    // counter_reset is never stored: it acts on the write edge itself
    assign w_cnt_clr   = w_wr_ctrl && reg_data[2];
    assign w_strobe_ev = r_s2 & ~r_s3 & r_strobe_mask;
    assign w_delta_ev  = (r_d2 ^ r_d3) & r_delta_mask;
    assign w_wrap      = r_capture_en && r_counter_en && (&r_cnt) && !w_cnt_clr;
    assign w_event     = r_capture_en && ((|w_strobe_ev) || (|w_delta_ev) || w_wrap);
    assign w_slot_free = !r_rdy || data_ack;
    assign w_unused    = ^reg_data;

    assign operate  = r_capture_en && r_counter_en;
    assign data_rdy = r_rdy;
    assign data     = r_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_capture_en  <= 1'b0;
            r_counter_en  <= 1'b0;
            r_strobe_mask <= '0;
            r_delta_mask  <= '0;
        end else if (reg_we) begin
            if (reg_addr == A_CTRL) begin
                r_capture_en <= reg_data[0];
                r_counter_en <= reg_data[1];
            end
            if (reg_addr == A_SMASK) r_strobe_mask <= reg_data[N_CH-1:0];
            if (reg_addr == A_DMASK) r_delta_mask  <= reg_data[N_DELTA-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_cnt_clr) begin
            r_cnt <= '0;
        end else if (r_counter_en) begin
            r_cnt <= r_cnt + TS_W'(1);
        end
    end

    // two synchroniser flops, third flop holds the previous level for edge detect
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1 <= '0;
            r_s2 <= '0;
            r_s3 <= '0;
            r_d1 <= '0;
            r_d2 <= '0;
            r_d3 <= '0;
        end else begin
            r_s1 <= strobe_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
            r_d1 <= delta_in;
            r_d2 <= r_d1;
            r_d3 <= r_d2;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdy       <= 1'b0;
            r_data      <= '0;
            r_lost_pend <= 1'b0;
        end else if (w_event) begin
            if (w_slot_free) begin
                r_data      <= {w_wrap, r_lost_pend, r_d2, w_strobe_ev, r_cnt};
                r_rdy       <= 1'b1;
                r_lost_pend <= 1'b0;
            end else begin
                r_lost_pend <= 1'b1;
            end
        end else if (data_ack) begin
            r_rdy <= 1'b0;
        end
    end
endmodule
